// File: rtl/accel_bcd_display.sv
// accel_bcd_display: signed 16-bit sample shown on six seven-segment digits via double-dabble
module accel_bcd_display #(
    parameter bit BLANK_ZEROS = 1'b1,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [15:0] value_in,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5
);
    typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;
    localparam logic [6:0] SEG_BLANK = ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
    localparam logic [6:0] SEG_MINUS = ACTIVE_LOW ? 7'b0111111 : 7'b1000000;
    function automatic logic [6:0] enc(input logic [3:0] d, input logic b);
        logic [6:0] s;
        case (d)
            4'd0: s = 7'b1000000;
            4'd1: s = 7'b1111001;
            4'd2: s = 7'b0100100;
            4'd3: s = 7'b0110000;
            4'd4: s = 7'b0011001;
            4'd5: s = 7'b0010010;
            4'd6: s = 7'b0000010;
            4'd7: s = 7'b1111000;
            4'd8: s = 7'b0000000;
            4'd9: s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        s = b ? 7'b1111111 : s;
        return ACTIVE_LOW ? s : ~s;
    endfunction
    state_t      state;
    logic [15:0] mag;
    logic [19:0] bcd;
    logic [19:0] adj;
    logic        sign;
    logic [3:0]  cnt;
    logic [4:1]  blank;
    logic        minus;
    // add-3 correction per BCD nibble, leading-zero chain and sign decision
    always_comb begin
        adj = bcd;
        for (int i = 0; i < 5; i++)
            adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
        blank[4] = BLANK_ZEROS && bcd[19:16] == 4'd0;
        blank[3] = blank[4] && bcd[15:12] == 4'd0;
        blank[2] = blank[3] && bcd[11:8] == 4'd0;
        blank[1] = blank[2] && bcd[7:4] == 4'd0;
        minus = sign && bcd != 20'd0;
    end
    // conversion FSM with registered busy, done and segment outputs
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= 4'd0;
            mag   <= 16'd0;
            bcd   <= 20'd0;
            sign  <= 1'b0;
            hex0  <= enc(4'd0, 1'b0);
            hex1  <= SEG_BLANK;
            hex2  <= SEG_BLANK;
            hex3  <= SEG_BLANK;
            hex4  <= SEG_BLANK;
            hex5  <= SEG_BLANK;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (load) begin
                    mag   <= value_in[15] ? ~value_in + 16'd1 : value_in;
                    sign  <= value_in[15];
                    bcd   <= 20'd0;
                    cnt   <= 4'd0;
                    busy  <= 1'b1;
                    state <= CONVERT;
                end
                CONVERT: begin
                    {bcd, mag} <= {adj, mag} << 1;
                    cnt        <= cnt + 4'd1;
                    state      <= cnt == 4'd15 ? UPDATE : CONVERT;
                end
                UPDATE: begin
                    hex0  <= enc(bcd[3:0], 1'b0);
                    hex1  <= enc(bcd[7:4], blank[1]);
                    hex2  <= enc(bcd[11:8], blank[2]);
                    hex3  <= enc(bcd[15:12], blank[3]);
                    hex4  <= enc(bcd[19:16], blank[4]);
                    hex5  <= minus ? SEG_MINUS : SEG_BLANK;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_accel_bcd_display.sv
// tb_accel_bcd_display: randomized and directed checks against a decimal-arithmetic display model
module tb_accel_bcd_display;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value_in = 16'd0;
    logic        load = 1'b0;
    logic        busy_a, done_a, busy_b, done_b;
    logic [6:0]  ha [6];
    logic [6:0]  hb [6];
    int          checks = 0;
    int          passes = 0;

    accel_bcd_display dut_a (
        .clk_clk(clk), .reset_reset(rst), .value_in(value_in), .load(load),
        .busy(busy_a), .done(done_a),
        .hex0(ha[0]), .hex1(ha[1]), .hex2(ha[2]), .hex3(ha[3]), .hex4(ha[4]), .hex5(ha[5])
    );

    accel_bcd_display #(.BLANK_ZEROS(1'b0), .ACTIVE_LOW(1'b0)) dut_b (
        .clk_clk(clk), .reset_reset(rst), .value_in(value_in), .load(load),
        .busy(busy_b), .done(done_b),
        .hex0(hb[0]), .hex1(hb[1]), .hex2(hb[2]), .hex3(hb[3]), .hex4(hb[4]), .hex5(hb[5])
    );

    always #5 clk = ~clk;

    // display model: decimal digits by division, blanking by magnitude comparison
    function automatic logic [6:0] exp_seg(input int v, input int pos, input bit bz, input bit al);
        logic [6:0] tbl [10];
        int p10 [5];
        int m;
        logic [6:0] s;
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        p10 = '{1, 10, 100, 1000, 10000};
        m = v < 0 ? -v : v;
        if (pos == 5) s = v < 0 ? 7'b0111111 : 7'b1111111;
        else if (bz && pos > 0 && m < p10[pos]) s = 7'b1111111;
        else s = tbl[(m / p10[pos]) % 10];
        return al ? s : ~s;
    endfunction

    function automatic logic [6:0] exp_rst(input int pos, input bit al);
        logic [6:0] s;
        s = pos == 0 ? 7'b1000000 : 7'b1111111;
        return al ? s : ~s;
    endfunction

    task automatic pulse_load(input int v);
        @(negedge clk);
        value_in = 16'(v);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        value_in = 16'($urandom);
    endtask

    // returns negedge index (0 = right after the load edge) at which done is seen, -1 on timeout
    task automatic wait_done(output int n, output int bc);
        n = -1;
        bc = 0;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clk);
            if (busy_a) bc++;
            if (done_a) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) $display("FAIL reset_ctrl busy=%b done=%b exp 0 0", busy_a, done_a); else passes++;
        for (int p = 0; p < 6; p++) begin
            checks++; if (ha[p] !== exp_rst(p, 1'b1)) $display("FAIL reset_a hex%0d got %b exp %b", p, ha[p], exp_rst(p, 1'b1)); else passes++;
            checks++; if (hb[p] !== exp_rst(p, 1'b0)) $display("FAIL reset_b hex%0d got %b exp %b", p, hb[p], exp_rst(p, 1'b0)); else passes++;
        end
        load = 1'b1;
        value_in = 16'd123;
        @(negedge clk);
        rst = 1'b0;
        load = 1'b0;
        checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0) $display("FAIL reset_load busy got %b%b exp 00", busy_a, busy_b); else passes++;
        begin
            int dc = 0;
            for (int i = 0; i < 25; i++) begin
                @(negedge clk);
                if (done_a || busy_a) dc++;
            end
            checks++; if (dc !== 0) $display("FAIL reset_load_activity got %0d exp 0", dc); else passes++;
        end
    endtask

    task automatic test_directed;
        int vals [10] = '{1234, -32768, 0, 32767, -7, 9, 10, -1, 100, 10000};
        int n, bc;
        foreach (vals[k]) begin
            pulse_load(vals[k]);
            wait_done(n, bc);
            checks++; if (n !== 17) $display("FAIL latency v=%0d got %0d exp 17", vals[k], n); else passes++;
            checks++; if (bc !== 17) $display("FAIL busy_len v=%0d got %0d exp 17", vals[k], bc); else passes++;
            checks++; if (done_b !== 1'b1) $display("FAIL done_b v=%0d got %b exp 1", vals[k], done_b); else passes++;
            for (int p = 0; p < 6; p++) begin
                checks++; if (ha[p] !== exp_seg(vals[k], p, 1'b1, 1'b1)) $display("FAIL dir_a v=%0d hex%0d got %b exp %b", vals[k], p, ha[p], exp_seg(vals[k], p, 1'b1, 1'b1)); else passes++;
                checks++; if (hb[p] !== exp_seg(vals[k], p, 1'b0, 1'b0)) $display("FAIL dir_b v=%0d hex%0d got %b exp %b", vals[k], p, hb[p], exp_seg(vals[k], p, 1'b0, 1'b0)); else passes++;
            end
            @(negedge clk);
            checks++; if (done_a !== 1'b0) $display("FAIL done_pulse v=%0d got %b exp 0", vals[k], done_a); else passes++;
        end
    endtask

    task automatic test_random;
        int prev = 10000;
        int n, bc;
        for (int t = 0; t < 40; t++) begin
            logic [15:0] r;
            int v;
            r = 16'($urandom);
            v = $signed(r);
            pulse_load(v);
            repeat (8) @(negedge clk);
            for (int p = 0; p < 6; p++) begin
                checks++; if (ha[p] !== exp_seg(prev, p, 1'b1, 1'b1)) $display("FAIL hold v=%0d hex%0d got %b exp %b", prev, p, ha[p], exp_seg(prev, p, 1'b1, 1'b1)); else passes++;
            end
            wait_done(n, bc);
            checks++; if (n < 0) $display("FAIL rand_timeout v=%0d got no done exp done", v); else passes++;
            for (int p = 0; p < 6; p++) begin
                checks++; if (ha[p] !== exp_seg(v, p, 1'b1, 1'b1)) $display("FAIL rand_a v=%0d hex%0d got %b exp %b", v, p, ha[p], exp_seg(v, p, 1'b1, 1'b1)); else passes++;
                checks++; if (hb[p] !== exp_seg(v, p, 1'b0, 1'b0)) $display("FAIL rand_b v=%0d hex%0d got %b exp %b", v, p, hb[p], exp_seg(v, p, 1'b0, 1'b0)); else passes++;
            end
            prev = v;
        end
    endtask

    task automatic test_ignore_load;
        int dc = 0;
        pulse_load(100);
        @(negedge clk);
        value_in = 16'd5;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 45; i++) begin
            if (done_a) dc++;
            @(negedge clk);
        end
        checks++; if (dc !== 1) $display("FAIL ignore_done_count got %0d exp 1", dc); else passes++;
        for (int p = 0; p < 6; p++) begin
            checks++; if (ha[p] !== exp_seg(100, p, 1'b1, 1'b1)) $display("FAIL ignore hex%0d got %b exp %b", p, ha[p], exp_seg(100, p, 1'b1, 1'b1)); else passes++;
        end
    endtask

    task automatic test_reset_abort;
        int dc = 0;
        int n, bc;
        pulse_load(9999);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (done_a || done_b) dc++;
            @(negedge clk);
        end
        checks++; if (dc !== 0) $display("FAIL abort_done got %0d exp 0", dc); else passes++;
        checks++; if (busy_a !== 1'b0) $display("FAIL abort_busy got %b exp 0", busy_a); else passes++;
        for (int p = 0; p < 6; p++) begin
            checks++; if (ha[p] !== exp_rst(p, 1'b1)) $display("FAIL abort_a hex%0d got %b exp %b", p, ha[p], exp_rst(p, 1'b1)); else passes++;
            checks++; if (hb[p] !== exp_rst(p, 1'b0)) $display("FAIL abort_b hex%0d got %b exp %b", p, hb[p], exp_rst(p, 1'b0)); else passes++;
        end
        pulse_load(-7);
        wait_done(n, bc);
        checks++; if (n !== 17) $display("FAIL after_abort_latency got %0d exp 17", n); else passes++;
        for (int p = 0; p < 6; p++) begin
            checks++; if (ha[p] !== exp_seg(-7, p, 1'b1, 1'b1)) $display("FAIL after_abort hex%0d got %b exp %b", p, ha[p], exp_seg(-7, p, 1'b1, 1'b1)); else passes++;
        end
    endtask

    task automatic test_back_to_back;
        int n, bc;
        pulse_load(1);
        wait_done(n, bc);
        checks++; if (n !== 17) $display("FAIL b2b_first got %0d exp 17", n); else passes++;
        value_in = 16'd2;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_done(n, bc);
        checks++; if (n + 1 !== 18) $display("FAIL b2b_spacing got %0d exp 18", n + 1); else passes++;
        for (int p = 0; p < 6; p++) begin
            checks++; if (ha[p] !== exp_seg(2, p, 1'b1, 1'b1)) $display("FAIL b2b hex%0d got %b exp %b", p, ha[p], exp_seg(2, p, 1'b1, 1'b1)); else passes++;
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_ignore_load;
        test_reset_abort;
        test_back_to_back;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/accel_bcd_display.md
ACCEL_BCD_DISPLAY -- requirements
Module: accel_bcd_display

Interface
REQ-001 Parameter BLANK_ZEROS, default 1: 1 = suppress leading zeros on hex4..hex1; 0 = show all digits.
REQ-002 Parameter ACTIVE_LOW, default 1: 1 = segment outputs active-low; 0 = all segment bits inverted.
REQ-003 clk_clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset_reset  input  1  synchronous, active-high reset.
REQ-005 value_in  input  16  signed two's-complement sample (accelerometer axis, mg).
REQ-006 load  input  1  one-cycle request to convert value_in.
REQ-007 busy  output  1  conversion in progress; load ignored while high.
REQ-008 done  output  1  one-cycle pulse when the hex outputs update.
REQ-009 hex0..hex5  output  7 each  segment vectors, bit order {g,f,e,d,c,b,a}; hex0 = least-significant digit, hex5 = sign.

Function
REQ-010 FSM states: IDLE, CONVERT, UPDATE; reset state IDLE.
REQ-011 IDLE with load=1: capture |value_in| as a 16-bit unsigned magnitude and sign = value_in[15]; clear the 20-bit BCD accumulator; clear the iteration counter; go to CONVERT.
REQ-012 Magnitude of -32768 (0x8000) is 32768, unsigned; no saturation.
REQ-013 CONVERT: one double-dabble step per cycle: add 3 to each BCD nibble >= 5, then shift {bcd, magnitude} left by 1.
REQ-014 CONVERT lasts exactly 16 cycles, counted by a 4-bit counter; after the 16th step go to UPDATE.
REQ-015 UPDATE: register all six hex outputs from the BCD result and sign; done = 1 for this cycle only; next state IDLE.
REQ-016 Latency: load sampled at edge k -> done high and new hex values visible in the cycle after edge k+17.
REQ-017 busy = 1 in CONVERT and UPDATE, 0 in IDLE.
REQ-018 load while busy = 1 is ignored, not queued; value_in is sampled only in IDLE.
REQ-019 hex outputs hold their last values during CONVERT; they change only in UPDATE or reset.
REQ-020 Digit encoding, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111, minus=0111111
REQ-021 Blanking with BLANK_ZEROS=1: digit i in 4..1 is blank when it and every higher digit are zero; hex0 always shows its digit.
REQ-022 hex5 shows minus when sign=1 and the magnitude is nonzero, else blank.
REQ-023 ACTIVE_LOW=0 outputs the bitwise inverse of every encoding in REQ-020.
REQ-024 load and reset_reset high in the same cycle: reset wins; no conversion starts.

Reset
REQ-025 While reset_reset = 1 at a clock edge: state IDLE, busy = 0, done = 0, counter and datapath cleared.
REQ-026 Reset display state: hex0 = digit 0 encoding, hex1..hex5 = blank.
REQ-027 Reset during CONVERT or UPDATE aborts the conversion; no done pulse; the display returns to the reset pattern.

Verification
REQ-028 value_in=1234, load pulse -> busy for 17 cycles; done pulse; hex3..hex0 = 1,2,3,4; hex4 = blank; hex5 = blank.
REQ-029 value_in=-32768 -> hex5 = minus; hex4..hex0 = 3,2,7,6,8.
REQ-030 value_in=0 -> hex0 = 1000000; hex1..hex5 = blank; with BLANK_ZEROS=0, hex1..hex4 = 1000000.
REQ-031 load 100 then a second load of 5 in cycle 3 -> second load ignored; exactly one done; display shows 100.
REQ-032 Load 9999, assert reset at cycle 8 -> no done pulse; reset pattern shown; a later load of -7 gives hex0 = 7, hex5 = minus, hex1..hex4 = blank.
REQ-033 Back-to-back loads of 1 and 2, each issued in the first IDLE cycle -> two done pulses 18 cycles apart; final display = 2.
